risc_toy_mem_arb: RTL and testbench



---
 rtl/risc_toy_mem_arb.sv | 151 +++++++++++++++
 tb/tb_risc_toy_mem_arb.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/risc_toy_mem_arb.sv
// Single-port memory arbiter for RISC_TOY: shares one memory port between fetch and load/store.
// Optional watchdog abort enabled by defining RISC_TOY_ARB_TIMEOUT_EN.
module risc_toy_mem_arb #(
    parameter int AW      = 30,
    parameter int DW      = 32,
    parameter int DSTARVE = 4,
    parameter int TIMEOUT = 255
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          I_REQ,
    input  logic [AW-1:0] I_ADDR,
    output logic          I_GNT,
    output logic          I_RVALID,
    output logic [DW-1:0] I_RDATA,
    input  logic          D_REQ,
    input  logic          D_RW,
    input  logic [AW-1:0] D_ADDR,
    input  logic [DW-1:0] D_WDATA,
    output logic          D_GNT,
    output logic          D_RVALID,
    output logic [DW-1:0] D_RDATA,
    output logic          M_REQ,
    output logic          M_RW,
    output logic [AW-1:0] M_ADDR,
    output logic [DW-1:0] M_WDATA,
    input  logic          M_ACK,
    input  logic [DW-1:0] M_RDATA,
    output logic          ERR
);
    localparam logic [3:0] DSTARVE_C = 4'(DSTARVE);

    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

    state_t        state, state_next;
    logic [3:0]    dcnt;
    logic          grant_i, grant_d;
    logic          timeout_hit;
    logic          finish;
    logic [DW-1:0] done_data;

    if (DSTARVE < 1 || DSTARVE > 15 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_param
        $error("risc_toy_mem_arb: DSTARVE must be 1..15 and TIMEOUT 1..255");
    end

`ifdef RISC_TOY_ARB_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

    logic [7:0] wdog;

    always_ff @(posedge CLK) begin
        if (RST || grant_i || grant_d || M_ACK) begin
            wdog <= '0;
        end else if (state != IDLE) begin
            wdog <= wdog + 8'd1;
        end
    end

    // A late ack on the final cycle still wins over the abort.
    assign timeout_hit = (state != IDLE) && !M_ACK && (wdog + 8'd1 == TIMEOUT_C);

    always_ff @(posedge CLK) begin
        if (RST) begin
            ERR <= 1'b0;
        end else if (timeout_hit) begin
            ERR <= 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign ERR         = 1'b0;
`endif

    assign finish    = (state != IDLE) && (M_ACK || timeout_hit);
    assign done_data = !M_ACK ? DW'(32'hDEAD_BEEF) : (M_RW ? '0 : M_RDATA);

    // Data wins ties unless fetch has already been passed over DSTARVE times.
    always_comb begin
        grant_i    = 1'b0;
        grant_d    = 1'b0;
        state_next = state;
        case (state)
            IDLE: begin
                if (!RST) begin
                    if (D_REQ && !(I_REQ && dcnt == DSTARVE_C)) begin
                        grant_d    = 1'b1;
                        state_next = BUSY_D;
                    end else if (I_REQ) begin
                        grant_i    = 1'b1;
                        state_next = BUSY_I;
                    end
                end
            end
            BUSY_I, BUSY_D: begin
                if (finish) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign I_GNT = grant_i;
    assign D_GNT = grant_d;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            dcnt     <= '0;
            M_REQ    <= 1'b0;
            M_RW     <= 1'b0;
            M_ADDR   <= '0;
            M_WDATA  <= '0;
            I_RVALID <= 1'b0;
            D_RVALID <= 1'b0;
            I_RDATA  <= '0;
            D_RDATA  <= '0;
        end else begin
            state    <= state_next;
            I_RVALID <= 1'b0;
            D_RVALID <= 1'b0;
            if (grant_i) begin
                M_REQ   <= 1'b1;
                M_RW    <= 1'b0;
                M_ADDR  <= I_ADDR;
                M_WDATA <= '0;
            end else if (grant_d) begin
                M_REQ   <= 1'b1;
                M_RW    <= D_RW;
                M_ADDR  <= D_ADDR;
                M_WDATA <= D_WDATA;
            end else if (finish) begin
                M_REQ <= 1'b0;
                if (state == BUSY_I) begin
                    I_RVALID <= 1'b1;
                    I_RDATA  <= done_data;
                end else begin
                    D_RVALID <= 1'b1;
                    D_RDATA  <= done_data;
                end
            end
            // Streak of data grants that bypassed a waiting fetch.
            if (!I_REQ || grant_i) begin
                dcnt <= '0;
            end else if (grant_d && dcnt != DSTARVE_C) begin
                dcnt <= dcnt + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_risc_toy_mem_arb.sv
// Self-checking bench for risc_toy_mem_arb: spec-level model checked every cycle plus directed literal checks.
// The watchdog scenario runs only when RISC_TOY_ARB_TIMEOUT_EN is defined.
module tb_risc_toy_mem_arb;
    localparam int AW      = 30;
    localparam int DW      = 32;
    localparam int DSTARVE = 4;
    localparam int TIMEOUT = 8;
`ifdef RISC_TOY_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          CLK = 1'b0;
    logic          RST;
    logic          I_REQ, D_REQ, D_RW;
    logic [AW-1:0] I_ADDR, D_ADDR;
    logic [DW-1:0] D_WDATA;
    logic          I_GNT, D_GNT, I_RVALID, D_RVALID, M_REQ, M_RW, ERR;
    logic [DW-1:0] I_RDATA, D_RDATA, M_WDATA;
    logic [AW-1:0] M_ADDR;
    logic          M_ACK;
    logic [DW-1:0] M_RDATA;

    int   checks   = 0;
    int   failures = 0;
    bit   started  = 1'b0;
    int   mem_lat  = 1;
    int   mem_cnt  = 0;
    logic mem_ack  = 1'b0;
    logic stray_ack = 1'b0;

    risc_toy_mem_arb #(.AW(AW), .DW(DW), .DSTARVE(DSTARVE), .TIMEOUT(TIMEOUT)) dut (
        .CLK(CLK), .RST(RST),
        .I_REQ(I_REQ), .I_ADDR(I_ADDR), .I_GNT(I_GNT), .I_RVALID(I_RVALID), .I_RDATA(I_RDATA),
        .D_REQ(D_REQ), .D_RW(D_RW), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA),
        .D_GNT(D_GNT), .D_RVALID(D_RVALID), .D_RDATA(D_RDATA),
        .M_REQ(M_REQ), .M_RW(M_RW), .M_ADDR(M_ADDR), .M_WDATA(M_WDATA),
        .M_ACK(M_ACK), .M_RDATA(M_RDATA), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem_word(input logic [29:0] a);
        if (a == 30'h10) return 32'h1234_5678;
        return {a, 2'b11} ^ 32'h0F0F_0000;
    endfunction

    assign M_ACK   = mem_ack | stray_ack;
    assign M_RDATA = mem_word(M_ADDR);

    // Memory acks once, mem_lat cycles into each request; mem_lat of 0 never acks.
    always begin
        @(posedge CLK);
        #1;
        if (M_REQ === 1'b1) mem_cnt = mem_cnt + 1;
        else mem_cnt = 0;
        mem_ack = (M_REQ === 1'b1) && (mem_lat != 0) && (mem_cnt == mem_lat);
    end

    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: one transaction in flight, owner 0 = none, 1 = fetch, 2 = data.
    int          m_owner  = 0;
    int          m_streak = 0;
    int          m_busy   = 0;
    logic [29:0] m_addr   = '0;
    logic        m_rw     = 1'b0;
    logic [31:0] m_wdata  = '0;
    logic        e_irv = 1'b0, e_drv = 1'b0, e_err = 1'b0;
    logic [31:0] e_ird = '0, e_drd = '0, e_data;
    logic        xi, xd;
    bit          deliver;

    always @(negedge CLK) begin
        xi = 1'b0;
        xd = 1'b0;
        if (RST !== 1'b1 && m_owner == 0) begin
            if (D_REQ && !(I_REQ && m_streak == DSTARVE)) xd = 1'b1;
            else if (I_REQ) xi = 1'b1;
        end
        if (started) begin
            check_val("I_GNT", 32'(I_GNT), 32'(xi));
            check_val("D_GNT", 32'(D_GNT), 32'(xd));
            check_val("M_REQ", 32'(M_REQ), 32'(m_owner != 0));
            check_val("I_RVALID", 32'(I_RVALID), 32'(e_irv));
            check_val("D_RVALID", 32'(D_RVALID), 32'(e_drv));
            check_val("I_RDATA", I_RDATA, e_ird);
            check_val("D_RDATA", D_RDATA, e_drd);
            check_val("ERR", 32'(ERR), 32'(e_err));
            if (m_owner != 0) begin
                check_val("M_RW", 32'(M_RW), 32'(m_rw));
                check_val("M_ADDR", 32'(M_ADDR), 32'(m_addr));
                if (m_rw) check_val("M_WDATA", M_WDATA, m_wdata);
            end
        end
        if (RST === 1'b1) begin
            m_owner = 0; m_streak = 0; m_busy = 0;
            e_irv = 1'b0; e_drv = 1'b0; e_err = 1'b0; e_ird = '0; e_drd = '0;
            started = 1'b1;
        end else begin
            e_irv = 1'b0;
            e_drv = 1'b0;
            if (m_owner == 0) begin
                if (xi) begin
                    m_owner = 1; m_addr = I_ADDR; m_rw = 1'b0; m_busy = 0;
                end else if (xd) begin
                    m_owner = 2; m_addr = D_ADDR; m_rw = D_RW; m_wdata = D_WDATA; m_busy = 0;
                end
            end else begin
                m_busy  = m_busy + 1;
                deliver = 1'b0;
                if (M_ACK) begin
                    deliver = 1'b1;
                    e_data  = m_rw ? 32'h0 : M_RDATA;
                end else if (TO_EN && m_busy == TIMEOUT) begin
                    deliver = 1'b1;
                    e_data  = 32'hDEAD_BEEF;
                    e_err   = 1'b1;
                end
                if (deliver) begin
                    if (m_owner == 1) begin e_irv = 1'b1; e_ird = e_data; end
                    else begin e_drv = 1'b1; e_drd = e_data; end
                    m_owner = 0;
                end
            end
            if (!I_REQ || xi) m_streak = 0;
            else if (xd && m_streak < DSTARVE) m_streak = m_streak + 1;
        end
    end

    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    logic seq [10];
    int   n;

    initial begin
        RST = 1'b1; I_REQ = 1'b0; D_REQ = 1'b0; D_RW = 1'b0;
        I_ADDR = '0; D_ADDR = '0; D_WDATA = '0;
        next_cycle();
        next_cycle();
        @(negedge CLK);
        check_val("rst_m_req", 32'(M_REQ), 32'h0);
        check_val("rst_i_rvalid", 32'(I_RVALID), 32'h0);
        check_val("rst_d_rdata", D_RDATA, 32'h0);
        check_val("rst_m_addr", 32'(M_ADDR), 32'h0);
        next_cycle();
        RST = 1'b0;
        next_cycle();

        // Single fetch, memory acks on the third request cycle.
        mem_lat = 3;
        I_REQ = 1'b1; I_ADDR = 30'h10;
        @(negedge CLK);
        check_val("fetch_gnt", 32'(I_GNT), 32'h1);
        next_cycle();
        I_REQ = 1'b0;
        @(negedge CLK);
        check_val("fetch_m_addr", 32'(M_ADDR), 32'h10);
        for (int k = 1; k <= 3; k++) begin
            if (k > 1) begin next_cycle(); @(negedge CLK); end
            check_val("fetch_m_req", 32'(M_REQ), 32'h1);
        end
        next_cycle();
        @(negedge CLK);
        check_val("fetch_rvalid", 32'(I_RVALID), 32'h1);
        check_val("fetch_rdata", I_RDATA, 32'h1234_5678);
        check_val("fetch_m_req_drop", 32'(M_REQ), 32'h0);
        next_cycle();

        // Collision: data write wins, fetch granted on the completion cycle.
        mem_lat = 1;
        I_REQ = 1'b1; I_ADDR = 30'h30;
        D_REQ = 1'b1; D_RW = 1'b1; D_ADDR = 30'h20; D_WDATA = 32'hA5A5_A5A5;
        @(negedge CLK);
        check_val("coll_d_gnt", 32'(D_GNT), 32'h1);
        check_val("coll_i_gnt", 32'(I_GNT), 32'h0);
        next_cycle();
        D_REQ = 1'b0;
        @(negedge CLK);
        check_val("coll_m_rw", 32'(M_RW), 32'h1);
        check_val("coll_m_wdata", M_WDATA, 32'hA5A5_A5A5);
        next_cycle();
        @(negedge CLK);
        check_val("coll_d_rvalid", 32'(D_RVALID), 32'h1);
        check_val("coll_d_rdata", D_RDATA, 32'h0);
        check_val("coll_i_gnt_after", 32'(I_GNT), 32'h1);
        next_cycle();
        I_REQ = 1'b0;
        next_cycle();
        @(negedge CLK);
        check_val("coll_i_rdata", I_RDATA, 32'h0F0F_00C3);
        next_cycle();
        next_cycle();

        // Starvation guard: both sides request continuously.
        I_REQ = 1'b1; I_ADDR = 30'h50;
        D_REQ = 1'b1; D_RW = 1'b0; D_ADDR = 30'h40;
        n = 0;
        for (int c = 0; c < 40 && n < 10; c++) begin
            @(negedge CLK);
            if (I_GNT || D_GNT) begin
                seq[n] = I_GNT;
                n = n + 1;
            end
            next_cycle();
        end
        I_REQ = 1'b0; D_REQ = 1'b0;
        check_val("starve_count", 32'(n), 32'd10);
        for (int i = 0; i < 10; i++) begin
            if (i < n) check_val("starve_pattern", 32'(seq[i]), 32'((i % 5) == 4));
        end
        next_cycle();
        next_cycle();
        next_cycle();

        // Reset in the middle of a data read that never completes.
        mem_lat = 0;
        D_REQ = 1'b1; D_RW = 1'b0; D_ADDR = 30'h60;
        @(negedge CLK);
        check_val("rst_mid_d_gnt", 32'(D_GNT), 32'h1);
        next_cycle();
        D_REQ = 1'b0;
        next_cycle();
        RST = 1'b1;
        next_cycle();
        RST = 1'b0; mem_lat = 2;
        I_REQ = 1'b1; I_ADDR = 30'h70;
        @(negedge CLK);
        check_val("rst_mid_m_req", 32'(M_REQ), 32'h0);
        check_val("rst_mid_d_rvalid", 32'(D_RVALID), 32'h0);
        check_val("rst_mid_i_gnt", 32'(I_GNT), 32'h1);
        next_cycle();
        I_REQ = 1'b0;
        next_cycle();
        next_cycle();
        @(negedge CLK);
        check_val("rst_mid_i_rvalid", 32'(I_RVALID), 32'h1);
        check_val("rst_mid_i_rdata", I_RDATA, 32'h0F0F_01C3);
        next_cycle();

        // Stray ack while idle must be ignored.
        stray_ack = 1'b1;
        next_cycle();
        stray_ack = 1'b0;
        @(negedge CLK);
        check_val("stray_i_rvalid", 32'(I_RVALID), 32'h0);
        check_val("stray_d_rvalid", 32'(D_RVALID), 32'h0);
        check_val("stray_m_req", 32'(M_REQ), 32'h0);
        next_cycle();

`ifdef RISC_TOY_ARB_TIMEOUT_EN
        // Fetch with no ack aborts after TIMEOUT busy cycles.
        mem_lat = 0;
        I_REQ = 1'b1; I_ADDR = 30'h80;
        @(negedge CLK);
        check_val("to_gnt", 32'(I_GNT), 32'h1);
        next_cycle();
        I_REQ = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            if (k > 1) next_cycle();
            @(negedge CLK);
            check_val("to_rvalid", 32'(I_RVALID), 32'(k == 9));
        end
        check_val("to_rdata", I_RDATA, 32'hDEAD_BEEF);
        check_val("to_err", 32'(ERR), 32'h1);
        next_cycle();
        next_cycle();
        @(negedge CLK);
        check_val("to_err_sticky", 32'(ERR), 32'h1);
        next_cycle();
        RST = 1'b1;
        next_cycle();
        RST = 1'b0;
        @(negedge CLK);
        check_val("to_err_cleared", 32'(ERR), 32'h0);
`else
        @(negedge CLK);
        check_val("err_tied_low", 32'(ERR), 32'h0);
`endif

        next_cycle();
        next_cycle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
